branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  ID-stage branch resolution unit; successor to the single BEQ/BNE comparator.
//  Resolves six MIPS branch conditions on forwarded rs/rt data at WIDTH bits.
//  Adds a 2-bit saturating branch history table (BHT) that is read in IF and updated here.
//  Flags mispredictions to the hazard unit; keeps saturating branch and mispredict statistics counters.
// PARAMETERS
//  WIDTH      32  operand width (rs/rt data)
//  PC_WIDTH   32  program counter width
//  BHT_DEPTH  16  BHT entries, power of 2, >=2; IDX_W = log2(BHT_DEPTH)
//  CNT_WIDTH  16  statistics counter width
// PORTS
//  Clk            in   1         system clock, rising edge
//  ResetN         in   1         synchronous reset, active low
//  LookupPC       in   PC_WIDTH  IF-stage PC for the prediction lookup
//  PredictTaken   out  1         BHT prediction for LookupPC (counter MSB), combinational
//  CompareFlag    in   1         ID instruction is a branch
//  Control        in   3         branch type: 0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved
//  InA            in   WIDTH     rs data, after forwarding
//  InB            in   WIDTH     rt data, after forwarding (used only by BEQ/BNE)
//  ResolvePC      in   PC_WIDTH  PC of the branch in ID
//  PredictedIn    in   1         prediction made in IF, carried down the IF/ID register
//  Stall          in   1         ID held this cycle; no state update
//  Flush          in   1         ID instruction squashed; no state update
//  Result         out  1         branch taken, combinational
//  Mispredict     out  1         Valid & (Result != PredictedIn), combinational
//  BranchCount    out  CNT_WIDTH resolved branches, saturating, registered
//  MispredCount   out  CNT_WIDTH mispredictions, saturating, registered
// BEHAVIOUR
//  Valid = CompareFlag & (Control in 1..6) & ~Stall & ~Flush.
//  Result is 0 unless CompareFlag=1 and Control in 1..6. Stall/Flush do not mask it.
//  Conditions: BEQ A==B; BNE A!=B; BLEZ $signed(A)<=0; BGTZ $signed(A)>0; BLTZ A[WIDTH-1]; BGEZ ~A[WIDTH-1].
//  Control 0 or 7 -> Result=0, Mispredict=0, no update.
//  Index = PC[IDX_W+1:2], word-aligned, for both lookup and resolve.
//  Lookup: PredictTaken = BHT[idx(LookupPC)][1]. Pure read with no bypass.
//    Same-cycle lookup and update of one entry returns the pre-update value.
//  Update on the rising Clk edge when Valid:
//    taken -> counter+1, saturating at 2'b11; not taken -> counter-1, saturating at 2'b00.
//  Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
//  BranchCount += 1 when Valid; MispredCount += 1 when Valid & Mispredict.
//    Both hold at all-ones and never wrap.
//  Latency: Result/Mispredict 0 cycles. BHT and counters visible the cycle after the edge.
//  Reset (ResetN=0 at edge): every BHT entry = 2'b01; BranchCount=MispredCount=0.
//    During reset, Result/Mispredict still follow the inputs combinationally; no updates occur.
//    Reset takes priority over a simultaneous Valid update.
//  Stall and Flush together are treated as Flush: no update.
// STRUCTURE
//  Shared package (mips_pkg): branch Control encodings BR_NONE..BR_BGEZ, 2-bit counter
//    reset value CTR_WEAK_NT, and the counter saturate-inc/dec function.
//  Sub-module bht_2bit (BHT_DEPTH x 2-bit register array):
//    one async read port, one sync write port, synchronous active-low reset.
//  The condition evaluator stays inline as a combinational always block.
// TESTING
//  1 BEQ/BNE: A=B=32'h5 -> BEQ Result=1, BNE 0; A=5,B=6 -> BEQ 0, BNE 1.
//  2 Sign compares: A=32'h8000_0000 -> BLTZ 1, BLEZ 1, BGTZ 0, BGEZ 0.
//    A=0 -> BLEZ 1, BGEZ 1, BGTZ 0, BLTZ 0.
//    Control=7 or CompareFlag=0 -> Result 0, no counter change.
//  3 Saturation: after reset, 3 taken BEQs at PC 0x40 -> counter 01->10->11->11;
//    PredictTaken(0x40)=1 from the cycle after the 1st update.
//    PC 0x80 (idx 0 when BHT_DEPTH=16) aliases PC 0x40's entry... use 0x44 (idx 1): still 01.
//  4 Mispredict: PredictedIn=0, taken branch -> Mispredict=1 same cycle.
//    MispredCount 0->1 and BranchCount 0->1 on the next edge.
//  5 Stall/Flush: valid taken branch with Stall=1, then Flush=1 -> Result=1 both cycles;
//    BHT and counters unchanged.
//  6 Same-cycle hazard and reset: lookup and resolve on the same index in one cycle ->
//    old prediction returned.
//    ResetN=0 mid-sequence with Valid=1 -> all entries 01, counters 0 next cycle.
//    Force BranchCount=16'hFFFF (CNT_WIDTH=16) -> stays 16'hFFFF after another branch.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Branch control encodings and 2-bit predictor counter helpers.
package mips_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_ctrl_e;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  // Saturating step of a 2-bit predictor counter.
  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       taken
  );
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: DEPTH x 2-bit saturating counters.
// Async read for IF lookup, clocked read-modify-write for ID resolve.
module bht_2bit
  import mips_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [1:0]               rdata_o,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic                     taken_i
);

  logic [1:0] mem_q [DEPTH];
  logic [1:0] wdata_d;

  // Next value of the entry being resolved.
  always_comb begin
    wdata_d = ctr_next(mem_q[waddr_i], taken_i);
  end

  // Reset all entries to weak not-taken; else update one entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= CTR_WEAK_NT;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_d;
    end
  end

  // Lookup sees the pre-update value.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution with 2-bit BHT prediction.
// Flags mispredictions and keeps saturating statistics.
module branch_resolve_unit
  import mips_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PC_WIDTH  = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic [PC_WIDTH-1:0]  LookupPC,
  output logic                 PredictTaken,
  input  logic                 CompareFlag,
  input  logic [2:0]           Control,
  input  logic [WIDTH-1:0]     InA,
  input  logic [WIDTH-1:0]     InB,
  input  logic [PC_WIDTH-1:0]  ResolvePC,
  input  logic                 PredictedIn,
  input  logic                 Stall,
  input  logic                 Flush,
  output logic                 Result,
  output logic                 Mispredict,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredCount
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  br_ctrl_e             ctrl;
  logic                 is_br;
  logic                 cond;
  logic                 valid;
  logic [1:0]           rd_ctr;
  logic [IDX_W-1:0]     lk_idx;
  logic [IDX_W-1:0]     rs_idx;
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;
  logic                 unused_pc;

  assign ctrl   = br_ctrl_e'(Control);
  assign lk_idx = LookupPC[IDX_W+1:2];
  assign rs_idx = ResolvePC[IDX_W+1:2];

  assign unused_pc = ^{LookupPC[PC_WIDTH-1:IDX_W+2],
                       LookupPC[1:0],
                       ResolvePC[PC_WIDTH-1:IDX_W+2],
                       ResolvePC[1:0]};

  // Evaluate the branch condition for the decoded type.
  always_comb begin
    is_br = 1'b0;
    cond  = 1'b0;
    unique case (ctrl)
      BR_BEQ: begin
        is_br = 1'b1;
        cond  = (InA == InB);
      end
      BR_BNE: begin
        is_br = 1'b1;
        cond  = (InA != InB);
      end
      BR_BLEZ: begin
        is_br = 1'b1;
        cond  = InA[WIDTH-1] | ~|InA;
      end
      BR_BGTZ: begin
        is_br = 1'b1;
        cond  = ~InA[WIDTH-1] & |InA;
      end
      BR_BLTZ: begin
        is_br = 1'b1;
        cond  = InA[WIDTH-1];
      end
      BR_BGEZ: begin
        is_br = 1'b1;
        cond  = ~InA[WIDTH-1];
      end
      default: begin
        is_br = 1'b0;
        cond  = 1'b0;
      end
    endcase
  end

  assign Result     = CompareFlag & is_br & cond;
  assign valid      = CompareFlag & is_br & ~Stall & ~Flush;
  assign Mispredict = valid & (Result ^ PredictedIn);

  bht_2bit #(
    .DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk_i   (Clk),
    .rst_ni  (ResetN),
    .raddr_i (lk_idx),
    .rdata_o (rd_ctr),
    .we_i    (valid),
    .waddr_i (rs_idx),
    .taken_i (Result)
  );

  assign PredictTaken = rd_ctr[1];

  // Saturating next values for the statistics counters.
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (valid && !(&bcnt_q)) bcnt_d = bcnt_q + CNT_WIDTH'(1);
    if (Mispredict && !(&mcnt_q)) mcnt_d = mcnt_q + CNT_WIDTH'(1);
  end

  // Statistics registers; reset wins over any update.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign BranchCount  = bcnt_q;
  assign MispredCount = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit.
// Table vectors, directed corner sequences and random run vs model.
module tb_branch_resolve_unit;

  logic        Clk;
  logic        ResetN;
  logic [31:0] LookupPC;
  logic        PredictTaken;
  logic        CompareFlag;
  logic [2:0]  Control;
  logic [31:0] InA, InB;
  logic [31:0] ResolvePC;
  logic        PredictedIn;
  logic        Stall, Flush;
  logic        Result, Mispredict;
  logic [15:0] BranchCount, MispredCount;

  logic        s_pt, s_res, s_mis;
  logic [3:0]  s_bc, s_mc;

  branch_resolve_unit dut (
    .Clk          (Clk),
    .ResetN       (ResetN),
    .LookupPC     (LookupPC),
    .PredictTaken (PredictTaken),
    .CompareFlag  (CompareFlag),
    .Control      (Control),
    .InA          (InA),
    .InB          (InB),
    .ResolvePC    (ResolvePC),
    .PredictedIn  (PredictedIn),
    .Stall        (Stall),
    .Flush        (Flush),
    .Result       (Result),
    .Mispredict   (Mispredict),
    .BranchCount  (BranchCount),
    .MispredCount (MispredCount)
  );

  branch_resolve_unit #(
    .BHT_DEPTH (2),
    .CNT_WIDTH (4)
  ) u_sat (
    .Clk          (Clk),
    .ResetN       (ResetN),
    .LookupPC     (LookupPC),
    .PredictTaken (s_pt),
    .CompareFlag  (CompareFlag),
    .Control      (Control),
    .InA          (InA),
    .InB          (InB),
    .ResolvePC    (ResolvePC),
    .PredictedIn  (PredictedIn),
    .Stall        (Stall),
    .Flush        (Flush),
    .Result       (s_res),
    .Mispredict   (s_mis),
    .BranchCount  (s_bc),
    .MispredCount (s_mc)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int errs = 0;
  int nchk = 0;

  int     bht_m [16];
  longint tot_b, tot_m;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic m_taken(input logic cf, input logic [2:0] c,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    int sa;
    sa = int'(a);
    if (!cf) return 1'b0;
    case (c)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return sa <= 0;
      3'd4:    return sa > 0;
      3'd5:    return sa < 0;
      3'd6:    return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_valid();
    return CompareFlag && (Control >= 3'd1) && (Control <= 3'd6)
           && !Stall && !Flush;
  endfunction

  function automatic logic m_mis();
    return m_valid() && (m_taken(CompareFlag, Control, InA, InB)
                         != PredictedIn);
  endfunction

  function automatic logic m_pt();
    return bht_m[(LookupPC / 4) % 16] >= 2;
  endfunction

  function automatic logic [31:0] sat(input longint v, input longint mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  // Compare combinational outputs, clock once, update model, compare state.
  task automatic step();
    logic tk;
    int   ix;
    #2;
    tk = m_taken(CompareFlag, Control, InA, InB);
    chk("result", {31'd0, Result}, {31'd0, tk});
    chk("mispredict", {31'd0, Mispredict}, {31'd0, m_mis()});
    chk("predict", {31'd0, PredictTaken}, {31'd0, m_pt()});
    @(posedge Clk);
    if (!ResetN) begin
      foreach (bht_m[i]) bht_m[i] = 1;
      tot_b = 0;
      tot_m = 0;
    end else if (m_valid()) begin
      ix = (ResolvePC / 4) % 16;
      if (tk) bht_m[ix] = (bht_m[ix] == 3) ? 3 : bht_m[ix] + 1;
      else    bht_m[ix] = (bht_m[ix] == 0) ? 0 : bht_m[ix] - 1;
      tot_b++;
      if (m_mis()) tot_m++;
    end
    #1;
    chk("branch_cnt", {16'd0, BranchCount}, sat(tot_b, 65535));
    chk("mispred_cnt", {16'd0, MispredCount}, sat(tot_m, 65535));
    chk("sat_branch_cnt", {28'd0, s_bc}, sat(tot_b, 15));
    chk("sat_mispred_cnt", {28'd0, s_mc}, sat(tot_m, 15));
  endtask

  task automatic br(input logic cf, input logic [2:0] c,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] rpc, input logic [31:0] lpc,
                    input logic pr, input logic st, input logic fl);
    CompareFlag = cf;
    Control     = c;
    InA         = a;
    InB         = b;
    ResolvePC   = rpc;
    LookupPC    = lpc;
    PredictedIn = pr;
    Stall       = st;
    Flush       = fl;
  endtask

  task automatic do_reset();
    br(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ResetN = 1'b0;
    step();
    step();
    ResetN = 1'b1;
  endtask

  typedef struct {
    logic        cf;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        stall;
    logic        flush;
    logic        er;
    logic        em;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 3'd1, 32'h5, 32'h5, 1, 0, 0, 1, 0};
    tbl[1]  = '{1, 3'd2, 32'h5, 32'h5, 1, 0, 0, 0, 1};
    tbl[2]  = '{1, 3'd1, 32'h5, 32'h6, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 3'd2, 32'h5, 32'h6, 0, 0, 0, 1, 1};
    tbl[4]  = '{1, 3'd5, 32'h8000_0000, 32'h0, 1, 0, 0, 1, 0};
    tbl[5]  = '{1, 3'd3, 32'h8000_0000, 32'h0, 0, 0, 0, 1, 1};
    tbl[6]  = '{1, 3'd4, 32'h8000_0000, 32'h0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 3'd6, 32'h8000_0000, 32'h0, 1, 0, 0, 0, 1};
    tbl[8]  = '{1, 3'd3, 32'h0, 32'h7, 1, 0, 0, 1, 0};
    tbl[9]  = '{1, 3'd6, 32'h0, 32'h7, 1, 0, 0, 1, 0};
    tbl[10] = '{1, 3'd4, 32'h0, 32'h7, 1, 0, 0, 0, 1};
    tbl[11] = '{1, 3'd5, 32'h0, 32'h7, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 3'd7, 32'h5, 32'h5, 1, 0, 0, 0, 0};
    tbl[13] = '{0, 3'd1, 32'h5, 32'h5, 1, 0, 0, 0, 0};
    tbl[14] = '{1, 3'd0, 32'h5, 32'h5, 1, 0, 0, 0, 0};
    tbl[15] = '{1, 3'd1, 32'h5, 32'h5, 0, 1, 0, 1, 0};
    tbl[16] = '{1, 3'd1, 32'h5, 32'h5, 0, 0, 1, 1, 0};
    tbl[17] = '{1, 3'd1, 32'h5, 32'h5, 0, 1, 1, 1, 0};
    tbl[18] = '{1, 3'd4, 32'h7fff_ffff, 32'h0, 1, 0, 0, 1, 0};

    foreach (bht_m[i]) bht_m[i] = 1;
    tot_b = 0;
    tot_m = 0;
    ResetN = 1'b0;
    br(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    do_reset();

    LookupPC = 32'h40;
    #1;
    chk("rst_branch_cnt", {16'd0, BranchCount}, 32'd0);
    chk("rst_mispred_cnt", {16'd0, MispredCount}, 32'd0);
    chk("rst_predict", {31'd0, PredictTaken}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      br(tbl[i].cf, tbl[i].ctrl, tbl[i].a, tbl[i].b, 32'h100, 32'h104,
         tbl[i].pred, tbl[i].stall, tbl[i].flush);
      #1;
      chk($sformatf("tbl%0d_result", i), {31'd0, Result},
          {31'd0, tbl[i].er});
      chk($sformatf("tbl%0d_mispred", i), {31'd0, Mispredict},
          {31'd0, tbl[i].em});
      step();
    end

    // Saturation and aliasing at PC 0x40.
    do_reset();
    br(1, 3'd1, 1, 1, 32'h40, 32'h40, 0, 0, 0);
    #1;
    chk("hz_same_cycle_old", {31'd0, PredictTaken}, 32'd0);
    chk("mis_same_cycle", {31'd0, Mispredict}, 32'd1);
    step();
    chk("mis_branch_cnt", {16'd0, BranchCount}, 32'd1);
    chk("mis_mispred_cnt", {16'd0, MispredCount}, 32'd1);
    chk("sat_pt_1", {31'd0, PredictTaken}, 32'd1);
    step();
    step();
    chk("sat_pt_3", {31'd0, PredictTaken}, 32'd1);
    LookupPC = 32'h80;
    #1;
    chk("alias_0x80", {31'd0, PredictTaken}, 32'd1);
    LookupPC = 32'h44;
    #1;
    chk("idx1_0x44", {31'd0, PredictTaken}, 32'd0);
    br(1, 3'd2, 1, 1, 32'h40, 32'h40, 1, 0, 0);
    step();
    chk("sat_down_11_10", {31'd0, PredictTaken}, 32'd1);
    step();
    chk("sat_down_10_01", {31'd0, PredictTaken}, 32'd0);

    // Stall then flush: no state change.
    br(1, 3'd1, 1, 1, 32'h48, 32'h48, 0, 1, 0);
    step();
    Stall = 0;
    Flush = 1;
    step();
    chk("stall_flush_cnt", {16'd0, BranchCount}, 32'd5);
    chk("stall_flush_pt", {31'd0, PredictTaken}, 32'd0);

    // Reset with a valid update pending.
    br(1, 3'd1, 1, 1, 32'h40, 32'h40, 1, 0, 0);
    step();
    chk("pre_rst_pt", {31'd0, PredictTaken}, 32'd1);
    ResetN = 1'b0;
    #1;
    chk("rst_result_live", {31'd0, Result}, 32'd1);
    step();
    ResetN = 1'b1;
    chk("midrst_branch_cnt", {16'd0, BranchCount}, 32'd0);
    chk("midrst_pt", {31'd0, PredictTaken}, 32'd0);

    // Counter saturation on the narrow instance.
    br(1, 3'd1, 1, 1, 32'h50, 32'h50, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat4_branch", {28'd0, s_bc}, 32'hF);
    chk("sat4_mispred", {28'd0, s_mc}, 32'hF);
    chk("wide_branch", {16'd0, BranchCount}, 32'd20);

    // Random run against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      ResetN = ($urandom_range(0, 59) != 0);
      case ($urandom_range(0, 3))
        0:       a = 32'h0;
        1:       a = 32'h8000_0000;
        2:       a = $urandom;
        default: a = 32'($urandom_range(0, 3));
      endcase
      br(($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)), a,
         ($urandom_range(0, 1) == 1) ? a : 32'($urandom_range(0, 3)),
         32'($urandom_range(0, 63)) << 2,
         32'($urandom_range(0, 63)) << 2,
         1'($urandom_range(0, 1)),
         ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
